// File: rtl/s4_pkg.sv
// s4_pkg: types and line levels shared by the s4 serial receiver and the
// matching transmitter.
package s4_pkg;

    // Receiver frame states; ST_PAR is only reached when parity is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } rx_state_t;

    // Level of an idle line and of the stop bit.
    localparam logic LINE_IDLE = 1'b1;
    // Level that marks the beginning of a frame.
    localparam logic START_BIT = 1'b0;

endpackage : s4_pkg

// File: rtl/s4_rx_shift.sv
// s4_rx_shift: DATA_W-bit assembly register for the serial receiver.
// MSB_FIRST=0 shifts right (new bit enters at the MSB, so the first bit
// ends up in the LSB); MSB_FIRST=1 shifts left (new bit enters at the LSB).
// With S4_SERIAL_RX_PARITY_EN defined it also keeps a running XOR of the
// bits shifted in since the last start.
module s4_rx_shift
    import s4_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              shift_en,
    input  logic              din,
`ifdef S4_SERIAL_RX_PARITY_EN
    output logic              parity,
`endif
    output logic [DATA_W-1:0] data
);

    // Assembly register: cleared at each start bit, shifted on each data bit.
    always_ff @(posedge clk or negedge clr) begin
        // NOTE: all state, including this data register, is reset so a frame
        // interrupted by clr leaves no stale bits behind.
        if (!clr) begin
            data <= '0;
        end else if (start) begin
            data <= '0;
        end else if (shift_en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of its neighbours.
            data <= MSB_FIRST ? {data[DATA_W-2:0], din} : {din, data[DATA_W-1:1]};
        end
    end

`ifdef S4_SERIAL_RX_PARITY_EN
    // Running even-parity accumulator over the data bits of the current frame.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            parity <= 1'b0;
        end else if (start) begin
            parity <= 1'b0;
        end else if (shift_en) begin
            parity <= parity ^ din;
        end
    end
`endif

endmodule : s4_rx_shift

// File: rtl/s4_serial_rx.sv
// s4_serial_rx: framed serial-to-parallel receiver with a valid/ready output.
// Frame: start(0), DATA_W data bits, optional even-parity bit, stop(1).
// Optional feature macro: S4_SERIAL_RX_PARITY_EN adds the parity bit and a
// live par_err; without it par_err is tied low.
module s4_serial_rx
    import s4_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ser_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              par_err,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  word;
    logic               start;
    logic               shift_en;

`ifdef S4_SERIAL_RX_PARITY_EN
    logic               parity;
    logic               par_bad;
    logic               par_err_q;
`endif

    // Shift-register controls decoded from the current state and strobe.
    assign start    = bit_en && (state == ST_IDLE) && (ser_in == START_BIT);
    assign shift_en = bit_en && (state == ST_DATA);
    assign busy     = (state != ST_IDLE);

    s4_rx_shift #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .shift_en (shift_en),
        .din      (ser_in),
`ifdef S4_SERIAL_RX_PARITY_EN
        .parity   (parity),
`endif
        .data     (word)
    );

`ifdef S4_SERIAL_RX_PARITY_EN
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    // Frame FSM, holding register, handshake and error/overrun flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef S4_SERIAL_RX_PARITY_EN
            par_bad    <= 1'b0;
            par_err_q  <= 1'b0;
`endif
        end else begin
            // Error flags are single-cycle pulses.
            frame_err <= 1'b0;
`ifdef S4_SERIAL_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // Clear first so a same-edge overrun below takes precedence.
            if (ovr_clr) begin
                overrun <= 1'b0;
            end
            // Consumer takes the word; a load below may re-assert valid.
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (ser_in == START_BIT) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
`ifdef S4_SERIAL_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef S4_SERIAL_RX_PARITY_EN
                            state   <= ST_PAR;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
`ifdef S4_SERIAL_RX_PARITY_EN
                    ST_PAR: begin
                        par_bad <= (ser_in != parity);
                        state   <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (ser_in != LINE_IDLE) begin
                            frame_err <= 1'b1;
`ifdef S4_SERIAL_RX_PARITY_EN
                        end else if (par_bad) begin
                            par_err_q <= 1'b1;
`endif
                        end else if (!dout_valid || dout_ready) begin
                            dout       <= word;
                            dout_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    // NOTE: a default arm keeps the case fully specified; in a
                    // clocked block this adds no latch, it just recovers from
                    // any unreachable encoding.
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : s4_serial_rx

// File: tb/tb_s4_serial_rx.sv
// tb_s4_serial_rx: scoreboard bench for s4_serial_rx. Two instances share the
// line: u_lsb (MSB_FIRST=0) and u_msb (MSB_FIRST=1), each with its own
// expected-word queue. Works with or without S4_SERIAL_RX_PARITY_EN.
module tb_s4_serial_rx;

    logic       clk = 1'b0;
    logic       clr;
    logic       ser_in;
    logic       bit_en;
    logic       dout_ready;
    logic       ovr_clr;

    logic [3:0] l_dout, m_dout;
    logic       l_valid, m_valid;
    logic       l_busy, m_busy;
    logic       l_ferr, m_ferr;
    logic       l_perr, m_perr;
    logic       l_ovr, m_ovr;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_l[$];
    logic [3:0] q_m[$];
    int n_push = 0, n_pop_l = 0, n_pop_m = 0;
    int obs_ferr_l = 0, obs_ferr_m = 0, obs_perr_l = 0, obs_perr_m = 0;
    int exp_ferr = 0, exp_perr = 0;
    bit gap = 1'b0;

    always #5 clk = ~clk;

    s4_serial_rx #(.DATA_W(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clr(clr), .ser_in(ser_in), .bit_en(bit_en),
        .dout(l_dout), .dout_valid(l_valid), .dout_ready(dout_ready),
        .busy(l_busy), .frame_err(l_ferr), .par_err(l_perr),
        .overrun(l_ovr), .ovr_clr(ovr_clr)
    );

    s4_serial_rx #(.DATA_W(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clr(clr), .ser_in(ser_in), .bit_en(bit_en),
        .dout(m_dout), .dout_valid(m_valid), .dout_ready(dout_ready),
        .busy(m_busy), .frame_err(m_ferr), .par_err(m_perr),
        .overrun(m_ovr), .ovr_clr(ovr_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the LSB-first instance: every accepted word is scored.
    always @(negedge clk) begin
        if (clr === 1'b1) begin
            if (l_valid && dout_ready) begin
                n_pop_l++;
                if (q_l.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lsb_word: got unexpected word 0x%0h, expected none", l_dout);
                end else begin
                    check("lsb_word", 32'(l_dout), 32'(q_l.pop_front()));
                end
            end
            if (l_ferr) obs_ferr_l++;
            if (l_perr) obs_perr_l++;
        end
    end

    // Monitor for the MSB-first instance.
    always @(negedge clk) begin
        if (clr === 1'b1) begin
            if (m_valid && dout_ready) begin
                n_pop_m++;
                if (q_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL msb_word: got unexpected word 0x%0h, expected none", m_dout);
                end else begin
                    check("msb_word", 32'(m_dout), 32'(q_m.pop_front()));
                end
            end
            if (m_ferr) obs_ferr_m++;
            if (m_perr) obs_perr_m++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_word(input logic [3:0] lsb_w, input logic [3:0] msb_w);
        q_l.push_back(lsb_w);
        q_m.push_back(msb_w);
        n_push++;
    endtask

    task automatic send_bit(input logic b);
        if (gap) begin
            bit_en = 1'b0;
            ser_in = ~b;
            @(posedge clk); #1;
        end
        ser_in = b;
        bit_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        ser_in = 1'b1;
        bit_en = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // seq[0] is the first data bit on the line; parity (if built) is correct.
    task automatic send_frame(input logic [3:0] seq, input logic stop, input bit ready_on_stop);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(seq[i]);
`ifdef S4_SERIAL_RX_PARITY_EN
        send_bit(^seq);
`endif
        if (ready_on_stop) dout_ready = 1'b1;
        send_bit(stop);
    endtask

`ifdef S4_SERIAL_RX_PARITY_EN
    task automatic send_bad_par(input logic [3:0] seq);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(seq[i]);
        send_bit(~(^seq));
        send_bit(1'b1);
    endtask
`endif

    task automatic check_errs(input string name);
        check({name, "_ferr_lsb"}, 32'(obs_ferr_l), 32'(exp_ferr));
        check({name, "_ferr_msb"}, 32'(obs_ferr_m), 32'(exp_ferr));
        check({name, "_perr_lsb"}, 32'(obs_perr_l), 32'(exp_perr));
        check({name, "_perr_msb"}, 32'(obs_perr_m), 32'(exp_perr));
    endtask

    initial begin
        clr        = 1'b0;
        ser_in     = 1'b1;
        bit_en     = 1'b0;
        dout_ready = 1'b1;
        ovr_clr    = 1'b0;
        #12;
        check("reset_lsb", {l_dout, l_valid, l_busy, l_ferr, l_perr, l_ovr}, 32'h0);
        check("reset_msb", {m_dout, m_valid, m_busy, m_ferr, m_perr, m_ovr}, 32'h0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;

        // Word 0xA: line bits 0,1,0,1 (MSB-first reading gives 0x5).
        expect_word(4'hA, 4'h5);
        send_frame(4'b1010, 1'b1, 1'b0);
        idle(3);
        check_errs("good_a");

`ifdef S4_SERIAL_RX_PARITY_EN
        // Correct parity then a flipped parity bit: only the first is kept.
        expect_word(4'hA, 4'h5);
        send_frame(4'b1010, 1'b1, 1'b0);
        send_bad_par(4'b1010);
        exp_perr++;
        idle(3);
        check_errs("parity");
`endif

        // Stop bit 0 on an all-ones frame, then back-to-back good 0x3.
        send_frame(4'b1111, 1'b0, 1'b0);
        exp_ferr++;
        expect_word(4'h3, 4'hC);
        send_frame(4'b0011, 1'b1, 1'b0);
        idle(3);
        check_errs("frame_err");

        // Overrun: 0x5 held, 0xC dropped.
        dout_ready = 1'b0;
        expect_word(4'h5, 4'hA);
        send_frame(4'b0101, 1'b1, 1'b0);
        send_frame(4'b1100, 1'b1, 1'b0);
        idle(1);
        check("ovr_set_lsb", 32'(l_ovr), 32'h1);
        check("ovr_set_msb", 32'(m_ovr), 32'h1);
        check("ovr_hold_lsb", 32'(l_dout), 32'h5);
        check("ovr_hold_msb", 32'(m_dout), 32'hA);
        dout_ready = 1'b1;
        idle(2);
        check("ovr_sticky", 32'(l_ovr), 32'h1);
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        check("ovr_clr_lsb", 32'(l_ovr), 32'h0);
        check("ovr_clr_msb", 32'(m_ovr), 32'h0);

        // Holding register accepted on the same edge the next word loads.
        dout_ready = 1'b0;
        expect_word(4'h5, 4'hA);
        send_frame(4'b0101, 1'b1, 1'b0);
        expect_word(4'hC, 4'h3);
        send_frame(4'b1100, 1'b1, 1'b1);
        idle(3);
        check("same_edge_ovr_lsb", 32'(l_ovr), 32'h0);
        check("same_edge_ovr_msb", 32'(m_ovr), 32'h0);

        // bit_en gaps between every bit with the line toggling meanwhile.
        gap = 1'b1;
        expect_word(4'h6, 4'h6);
        send_frame(4'b0110, 1'b1, 1'b0);
        gap = 1'b0;
        idle(3);

        // Line bits 1,0,0,0: MSB-first reading is 0x8, LSB-first is 0x1.
        expect_word(4'h1, 4'h8);
        send_frame(4'b0001, 1'b1, 1'b0);
        idle(3);
        check_errs("msb_first");

        // Reset mid-frame after two data bits.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("busy_lsb", 32'(l_busy), 32'h1);
        check("busy_msb", 32'(m_busy), 32'h1);
        clr = 1'b0;
        #1;
        check("midreset_lsb", {l_dout, l_valid, l_busy, l_ferr, l_perr, l_ovr}, 32'h0);
        check("midreset_msb", {m_dout, m_valid, m_busy, m_ferr, m_perr, m_ovr}, 32'h0);
        @(negedge clk);
        clr = 1'b1;
        idle(1);
        expect_word(4'h6, 4'h6);
        send_frame(4'b0110, 1'b1, 1'b0);
        idle(4);
        check("busy_idle", 32'(l_busy), 32'h0);

        check_errs("final");
        check("q_lsb_empty", 32'(q_l.size()), 32'h0);
        check("q_msb_empty", 32'(q_m.size()), 32'h0);
        check("words_lsb", 32'(n_pop_l), 32'(n_push));
        check("words_msb", 32'(n_pop_m), 32'(n_push));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_s4_serial_rx

// File: doc/s4_serial_rx.md
# s4_serial_rx

Serial-to-parallel framed receiver that turns the single-bit stream shifted out of the team's 4-bit universal shift register back into parallel words. It samples one bit per `bit_en` strobe, detects a start bit, assembles `DATA_W` data bits, checks stop (and optionally parity), and presents each word on a valid/ready output port. It sits at the far end of the serial link, between the line and the consuming logic.

## Interface
- `DATA_W`, 4: data bits per frame, range 2..16.
- `MSB_FIRST`, 0: 0 = first data bit is word LSB (matches shift-right output); 1 = first data bit is word MSB (matches shift-left output).
- `clk`  in  1  clock; all state changes on rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `ser_in`  in  1  serial line; idles high.
- `bit_en`  in  1  one-cycle sample strobe; `ser_in` is sampled only on edges where `bit_en`=1.
- `dout`  out  DATA_W  received word; stable while `dout_valid`=1.
- `dout_valid`  out  1  word available.
- `dout_ready`  in  1  consumer accepts the word when `dout_valid` & `dout_ready`.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `par_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without parity).
- `overrun`  out  1  sticky: a good word was dropped because the holding register was full.
- `ovr_clr`  in  1  synchronous clear of `overrun`.

## Operation
- Frame on the line: start (0), `DATA_W` data bits, [even-parity bit], stop (1).
- States: IDLE, DATA, PAR, STOP. Transitions occur only on `bit_en` edges.
- IDLE: `ser_in`=0 → DATA, bit counter = 0; `ser_in`=1 → remain in IDLE.
- DATA: shift `ser_in` into the assembly register (right-shift into MSB when `MSB_FIRST`=0, left-shift into LSB when 1). Increment the counter; after bit `DATA_W-1` → PAR (parity built) or STOP.
- PAR: compare `ser_in` with the XOR of the data bits (even parity). Record the mismatch. → STOP.
- STOP, `ser_in`=1 with no parity mismatch: word is good → IDLE.
- STOP, `ser_in`=0: pulse `frame_err`, discard the word, → IDLE. A new start bit is recognised only on a later `bit_en`.
- STOP, parity mismatch (stop=1): pulse `par_err`, discard the word → IDLE. If the stop bit is also 0, only `frame_err` pulses.
- Good word, holding register empty or being accepted this same cycle: load `dout`, `dout_valid`=1.
- Good word, holding register full and not accepted this cycle: keep the old `dout`, set `overrun`, drop the new word.
- Handshake: `dout_valid` falls on the edge where `dout_ready`=1, unless a new good word loads on that same edge, in which case it stays 1 with the new data.
- `ovr_clr` and a new overrun on the same edge: `overrun` ends at 1 (set wins).

## Timing
- Reset (`clr`=0, any time, including mid-frame): state IDLE, counter 0, assembly register 0. Outputs: `dout`=0, `dout_valid`=0, `busy`=0, `frame_err`=0, `par_err`=0, `overrun`=0.
- Latency: `dout`/`dout_valid` update on the same rising edge that samples a good stop bit, so they are visible the following cycle.
- `frame_err`/`par_err` are registered: high for exactly one cycle after the stop-sampling edge.
- `busy` rises on the edge that samples the start bit and falls on the stop-sampling edge.
- `bit_en`=0 cycles freeze all frame state. The handshake and `ovr_clr` still act every cycle.
- `bit_en` may be continuously high, giving one bit per clock; back-to-back frames need no idle gap.

## Configuration
- `S4_SERIAL_RX_PARITY_EN` defined: PAR state present; frame length is `DATA_W`+3 bits; `par_err` is live.
- Not defined: PAR state and parity logic are absent; frame length is `DATA_W`+2 bits; `par_err` is tied 0.

## Structure
- Shared package `s4_pkg`: the receiver state enum (IDLE/DATA/PAR/STOP) and constants for idle line level (1) and start bit level (0), shared with the matching transmitter.
- One sub-module, `s4_rx_shift`: a `DATA_W` shift register with enable, direction select and running parity. The FSM, counter, holding register and flags live in the top level.

## Test plan
- No parity, `MSB_FIRST`=0, `bit_en`=1, `dout_ready`=1; send 0,0,1,0,1,1 → `dout`=4'hA, `dout_valid` high for 1 cycle, no error pulses.
- Parity on; send 4'hA frame 0,0,1,0,1,0,1 → `dout`=4'hA. Repeat with parity bit 1 → `par_err` pulses once, `dout_valid` stays 0.
- Stop bit 0 (0,1,1,1,1,0) → `frame_err` pulses once, no word. An immediately following good frame for 4'h3 → `dout`=4'h3.
- `dout_ready`=0; send 4'h5 then 4'hC → `dout` stays 4'h5 and `overrun`=1. Assert `ovr_clr` → `overrun`=0. With `dout_ready`=1 on the cycle the second word loads → `dout`=4'hC and no overrun.
- `MSB_FIRST`=1; send 0,1,0,0,0,1 → `dout`=4'h8.
- Drop `clr` after 2 data bits → all outputs 0 immediately. Release `clr` and send a full frame for 4'h6 → `dout`=4'h6.
